// File: rtl/lab7_2_pkg.sv
// Shared definitions for the lab7_2 push-button front end: classifier state
// encoding and the 100 Hz scan-clock timing constants.
package lab7_2_pkg;

   typedef logic [1:0] btn_state_t;

   localparam btn_state_t S_IDLE  = 2'd0;
   localparam btn_state_t S_PRESS = 2'd1;
   localparam btn_state_t S_HELD  = 2'd2;

   // 2 s long-press threshold and 4 Hz auto-repeat at the 100 Hz scan clock
   localparam int LONG_2S = 200;
   localparam int REP_4HZ = 25;

endpackage

// File: rtl/lab7_2_btn_debounce.sv
// Two-flop synchronizer plus DEB_LEN-sample shift register; the debounced
// level only moves when every sample in the window agrees.
module lab7_2_btn_debounce
   import lab7_2_pkg::*;
#(
   parameter int DEB_LEN = 4
) (
   input  logic clk_100,
   input  logic rst_n,
   input  logic pb_in,
   output logic level_next,
   output logic pressed
);

   logic               sync_p0;
   logic               sync_p1;
   logic [DEB_LEN-1:0] window;

   // level_next is the value pressed takes on the coming edge; the classifier
   // reacts to it so its pulses line up with the edge pressed itself changes
   always_comb begin
      level_next = pressed;
      if (&window)
         level_next = 1'b1;
      else if (~|window)
         level_next = 1'b0;
   end

   always_ff @(posedge clk_100 or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         window  <= '0;
         pressed <= 1'b0;
      end else begin
         sync_p0 <= pb_in;
         sync_p1 <= sync_p0;
         window  <= {window[DEB_LEN-2:0], sync_p1};
         pressed <= level_next;
      end
   end

endmodule

// File: rtl/lab7_2_btn_event.sv
// Push-button event classifier: debounced level plus short, long and
// auto-repeat pulses for the lab7_2 countdown timer control FSM.
module lab7_2_btn_event
   import lab7_2_pkg::*;
#(
   parameter int DEB_LEN  = 4,
   parameter int LONG_CNT = LONG_2S,
   parameter int REP_CNT  = REP_4HZ,
   parameter int CNT_W    = 8
) (
   input  logic clk_100,
   input  logic rst_n,
   input  logic pb_in,
   output logic pressed,
   output logic short_pulse,
   output logic long_pulse,
   output logic rep_pulse
);

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = (REP_CNT == 0) ? '0 : CNT_W'(REP_CNT - 1);

   btn_state_t       state;
   logic [CNT_W-1:0] hold_cnt;
   logic [CNT_W-1:0] rep_cnt;
   logic             level_next;
   logic             rise;
   logic             fall;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   lab7_2_btn_debounce #(
      .DEB_LEN (DEB_LEN)
   ) u_debounce (
      .clk_100    (clk_100),
      .rst_n      (rst_n),
      .pb_in      (pb_in),
      .level_next (level_next),
      .pressed    (pressed)
   );

   assign rise = level_next & ~pressed;
   assign fall = ~level_next & pressed;

   always_ff @(posedge clk_100 or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         hold_cnt    <= '0;
         rep_cnt     <= '0;
         short_pulse <= 1'b0;
         long_pulse  <= 1'b0;
         rep_pulse   <= 1'b0;
      end else begin
         short_pulse <= 1'b0;
         long_pulse  <= 1'b0;
         rep_pulse   <= 1'b0;
         case (state)
            S_IDLE: begin
               hold_cnt <= '0;
               rep_cnt  <= '0;
               if (rise)
                  state <= S_PRESS;
            end
            S_PRESS: begin
               // a release on the threshold cycle is still a short press
               if (fall) begin
                  short_pulse <= 1'b1;
                  state       <= S_IDLE;
                  hold_cnt    <= '0;
                  rep_cnt     <= '0;
               end else if (hold_cnt == LONG_LAST) begin
                  long_pulse <= 1'b1;
                  rep_cnt    <= '0;
                  hold_cnt   <= sat_inc(hold_cnt);
                  state      <= S_HELD;
               end else begin
                  hold_cnt <= sat_inc(hold_cnt);
               end
            end
            S_HELD: begin
               if (fall) begin
                  state    <= S_IDLE;
                  hold_cnt <= '0;
                  rep_cnt  <= '0;
               end else begin
                  hold_cnt <= sat_inc(hold_cnt);
                  if (REP_CNT != 0) begin
                     if (rep_cnt == REP_LAST) begin
                        rep_pulse <= 1'b1;
                        rep_cnt   <= '0;
                     end else begin
                        rep_cnt <= sat_inc(rep_cnt);
                     end
                  end
               end
            end
            default: begin
               state    <= S_IDLE;
               hold_cnt <= '0;
               rep_cnt  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lab7_2_btn_event.sv
// Directed bench for lab7_2_btn_event: one build with auto-repeat every 3
// cycles and one with repeat disabled, both fed the same button.
module tb_lab7_2_btn_event;

   logic clk_100 = 1'b0;
   logic rst_n   = 1'b0;
   logic pb_in   = 1'b0;
   logic pressed, short_pulse, long_pulse, rep_pulse;
   logic pressed0, short0, long0, rep0;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   logic pressed_prev = 1'b0;

   int rise_q[$];
   int short_q[$];
   int long_q[$];
   int rep_q[$];
   int short0_q[$];
   int long0_q[$];
   int rep0_q[$];

   lab7_2_btn_event #(.DEB_LEN(4), .LONG_CNT(8), .REP_CNT(3), .CNT_W(8)) dut (
      .clk_100     (clk_100),
      .rst_n       (rst_n),
      .pb_in       (pb_in),
      .pressed     (pressed),
      .short_pulse (short_pulse),
      .long_pulse  (long_pulse),
      .rep_pulse   (rep_pulse)
   );

   lab7_2_btn_event #(.DEB_LEN(4), .LONG_CNT(8), .REP_CNT(0), .CNT_W(8)) dut0 (
      .clk_100     (clk_100),
      .rst_n       (rst_n),
      .pb_in       (pb_in),
      .pressed     (pressed0),
      .short_pulse (short0),
      .long_pulse  (long0),
      .rep_pulse   (rep0)
   );

   always #5 clk_100 = ~clk_100;

   always @(posedge clk_100) cyc <= cyc + 1;

   // cyc at a falling edge is the index of the rising edge that produced the value
   always @(negedge clk_100) begin
      if (pressed && !pressed_prev) rise_q.push_back(cyc);
      pressed_prev = pressed;
      if (short_pulse) short_q.push_back(cyc);
      if (long_pulse)  long_q.push_back(cyc);
      if (rep_pulse)   rep_q.push_back(cyc);
      if (short0)      short0_q.push_back(cyc);
      if (long0)       long0_q.push_back(cyc);
      if (rep0)        rep0_q.push_back(cyc);
   end

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_100);
      #1;
   endtask

   task automatic clr();
      rise_q.delete();
      short_q.delete();
      long_q.delete();
      rep_q.delete();
      short0_q.delete();
      long0_q.delete();
      rep0_q.delete();
   endtask

   // Offsets are rising edges after the edge preceding the first high sample;
   // -1 means the pulse must not appear.
   task automatic press_case(input string tag, input int n, input int exp_short,
                             input int exp_long, input int exp_reps);
      int c0;
      clr();
      c0 = cyc;
      pb_in = 1'b1;
      tick(n);
      pb_in = 1'b0;
      tick(20);
      check({tag, "_rise_n"}, rise_q.size(), 1);
      if (rise_q.size() > 0) check({tag, "_rise_at"}, rise_q[0] - c0, 7);
      check({tag, "_short_n"}, short_q.size(), (exp_short < 0) ? 0 : 1);
      if (exp_short >= 0 && short_q.size() > 0)
         check({tag, "_short_at"}, short_q[0] - c0, exp_short);
      check({tag, "_long_n"}, long_q.size(), (exp_long < 0) ? 0 : 1);
      if (exp_long >= 0 && long_q.size() > 0)
         check({tag, "_long_at"}, long_q[0] - c0, exp_long);
      check({tag, "_rep_n"}, rep_q.size(), exp_reps);
      check({tag, "_r0_long_n"}, long0_q.size(), (exp_long < 0) ? 0 : 1);
      check({tag, "_r0_short_n"}, short0_q.size(), (exp_short < 0) ? 0 : 1);
      check({tag, "_r0_rep_n"}, rep0_q.size(), 0);
   endtask

   initial begin
      int runs[22] = '{3, 1, 2, 3, 1, 2, 3, 3, 2, 1, 3, 2, 1, 3, 2, 3, 3, 1, 2, 3, 1, 2};
      int c0;
      int r;

      #2;
      check("reset_pressed", int'(pressed), 0);
      check("reset_pulses", int'({short_pulse, long_pulse, rep_pulse}), 0);
      tick(2);
      rst_n = 1'b1;
      tick(3);
      clr();

      // short press: pressed up at +7, released after 5 samples, falls at +12
      press_case("short5", 5, 12, -1, 0);

      // long press held 30 cycles: long at +15, repeats every 3 cycles until the fall at +37
      press_case("long30", 30, -1, 15, 7);
      if (rep_q.size() == 7) begin
         check("long30_rep_first", rep_q[0] - long_q[0], 3);
         check("long30_rep_second", rep_q[1] - long_q[0], 6);
         check("long30_rep_last", rep_q[6] - long_q[0], 21);
      end

      // release landing one edge before, exactly on, and one edge after the threshold
      press_case("edge7", 7, 14, -1, 0);
      press_case("edge8", 8, 15, -1, 0);
      press_case("edge9", 9, -1, 15, 0);

      // bounce with runs of 1..3 samples never settles
      clr();
      for (int i = 0; i < 22; i++) begin
         pb_in = (i % 2 == 0);
         tick(runs[i]);
      end
      pb_in = 1'b0;
      tick(15);
      check("glitch_rise_n", rise_q.size(), 0);
      check("glitch_short_n", short_q.size(), 0);
      check("glitch_long_n", long_q.size(), 0);
      check("glitch_rep_n", rep_q.size(), 0);

      // reset in the middle of HELD with the button still down
      clr();
      c0 = cyc;
      pb_in = 1'b1;
      tick(20);
      check("held_before_reset", int'(pressed), 1);
      rst_n = 1'b0;
      #1;
      check("rst_pressed", int'(pressed), 0);
      check("rst_pulses", int'({short_pulse, long_pulse, rep_pulse}), 0);
      check("rst_r0_pressed", int'(pressed0), 0);
      clr();
      tick(2);
      rst_n = 1'b1;
      r = cyc;
      tick(25);
      pb_in = 1'b0;
      tick(20);
      check("rst_rise_n", rise_q.size(), 1);
      if (rise_q.size() > 0) check("rst_rise_at", rise_q[0] - r, 7);
      check("rst_long_n", long_q.size(), 1);
      if (long_q.size() > 0) check("rst_long_at", long_q[0] - r, 15);
      check("rst_short_n", short_q.size(), 0);
      check("rst_rep_n", rep_q.size(), 5);
      if (rep_q.size() > 0) check("rst_rep_first", rep_q[0] - r, 18);
      check("rst_r0_long_n", long0_q.size(), 1);
      check("rst_r0_rep_n", rep0_q.size(), 0);
      check("rst_r0_short_n", short0_q.size(), 0);
      check("final_pressed", int'(pressed), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
